// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI peripheral receive path.
// Frame states, byte/address widths and watchdog defaults.
package spi_pkg;

  typedef enum logic {
    S_ADDR,
    S_DATA
  } frame_state_t;

  localparam int BYTE_W = 8;
  localparam int ADDR_W = 8;

  localparam int STOP_TIMEOUT_DEF = 64;
  localparam int STOP_PULSE_DEF   = 4;
  localparam int SYNC_STAGES_DEF  = 2;

  // Width able to hold values 0..n inclusive.
  function automatic int cnt_w(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sclk_idle_detector.sv
// iclk-domain watchdog: declares sclk idle and emits a one-shot
// active-low frame reset, re-armed by the next sclk edge.
module sclk_idle_detector
  import spi_pkg::*;
#(
  parameter int STOP_TIMEOUT = STOP_TIMEOUT_DEF,
  parameter int STOP_PULSE   = STOP_PULSE_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic iclk,
  input  logic rstn,
  input  logic sclk,
  output logic sclk_stop_rstn
);

  localparam int CW = cnt_w(STOP_TIMEOUT);
  localparam int PW = cnt_w(STOP_PULSE);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   sclk_edge;
  logic [CW-1:0]          idle_cnt;
  logic [PW-1:0]          pulse_cnt;
  logic                   armed_q;
  logic                   stop_q;
  logic                   idle_hit;
  logic                   pulse_end;

  assign sclk_edge = sync_q[SYNC_STAGES-1] ^ hist_q;
  assign idle_hit  = (idle_cnt == CW'(STOP_TIMEOUT));
  assign pulse_end = ~stop_q & (pulse_cnt == '0);

  assign sclk_stop_rstn = stop_q;

  // Bring sclk into iclk and keep one history stage for edges.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      sync_q <= '0;
      hist_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sclk};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Count iclk cycles since the last edge, saturating.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      idle_cnt <= '0;
    end else if (sclk_edge) begin
      idle_cnt <= '0;
    end else if (!idle_hit) begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

  // One-shot low pulse on idle, disarmed until sclk moves again.
  always_ff @(posedge iclk or negedge rstn) begin
    if (!rstn) begin
      stop_q    <= 1'b1;
      pulse_cnt <= '0;
      armed_q   <= 1'b0;
    end else begin
      if (!stop_q) begin
        if (pulse_cnt == '0) begin
          stop_q <= 1'b1;
        end else begin
          pulse_cnt <= pulse_cnt - 1'b1;
        end
      end else if (armed_q && idle_hit) begin
        stop_q    <= 1'b0;
        pulse_cnt <= PW'(STOP_PULSE - 1);
      end
      if (sclk_edge) begin
        armed_q <= 1'b1;
      end else if (pulse_end) begin
        armed_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/spi_pico_deframer.sv
// SPI receive framer: address byte then auto-incrementing data
// bytes, with an iclk watchdog that restarts framing on sclk idle.
module spi_pico_deframer
  import spi_pkg::*;
#(
  parameter int STOP_TIMEOUT = STOP_TIMEOUT_DEF,
  parameter int STOP_PULSE   = STOP_PULSE_DEF,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEF
) (
  input  logic              sclk,
  input  logic              rstn,
  input  logic              iclk,
  input  logic              serial_in,
  output logic              msg_flag,
  output logic              sclk_stop_rstn,
  output logic [BYTE_W-1:0] write_data,
  output logic [ADDR_W-1:0] mux_control_signal
);

  localparam int BCW = $clog2(BYTE_W);

  frame_state_t      state;
  logic [BCW-1:0]    bit_cnt;
  logic [BYTE_W-1:0] shift_reg;
  logic [BYTE_W-1:0] rx_byte;
  logic              byte_done;
  logic              frame_rstn;

  assign frame_rstn = rstn & sclk_stop_rstn;
  assign byte_done  = (bit_cnt == BCW'(BYTE_W - 1));
  assign rx_byte    = {serial_in, shift_reg[BYTE_W-1:1]};

  sclk_idle_detector #(
    .STOP_TIMEOUT (STOP_TIMEOUT),
    .STOP_PULSE   (STOP_PULSE),
    .SYNC_STAGES  (SYNC_STAGES)
  ) u_idle (
    .iclk           (iclk),
    .rstn           (rstn),
    .sclk           (sclk),
    .sclk_stop_rstn (sclk_stop_rstn)
  );

  // Shift LSB-first bits in; first byte is the address, rest data.
  always_ff @(posedge sclk or negedge frame_rstn) begin
    if (!frame_rstn) begin
      state              <= S_ADDR;
      bit_cnt            <= '0;
      shift_reg          <= '0;
      msg_flag           <= 1'b0;
      write_data         <= '0;
      mux_control_signal <= '0;
    end else begin
      shift_reg <= rx_byte;
      bit_cnt   <= bit_cnt + 1'b1;
      msg_flag  <= byte_done;
      if (byte_done) begin
        unique case (state)
          S_ADDR: begin
            mux_control_signal <= rx_byte;
            state              <= S_DATA;
          end
          S_DATA: begin
            write_data         <= rx_byte;
            mux_control_signal <= mux_control_signal + 1'b1;
          end
          default: state <= S_ADDR;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_pico_deframer.sv
// Randomised bench for spi_pico_deframer against a byte-level
// reference model of the address/data framing and idle watchdog.
module tb_spi_pico_deframer;

  logic       sclk;
  logic       rstn;
  logic       iclk;
  logic       serial_in;
  logic       msg_flag;
  logic       sclk_stop_rstn;
  logic [7:0] write_data;
  logic [7:0] mux_control_signal;

  int n_chk;
  int n_fail;
  int stop_low_cnt;

  logic [7:0] frm[$];

  int         m_bits;
  int         m_nbytes;
  logic [7:0] m_cur;
  logic [7:0] m_addr;
  logic [7:0] m_wd;
  logic       m_flag;

  spi_pico_deframer #(
    .STOP_TIMEOUT (64),
    .STOP_PULSE   (4),
    .SYNC_STAGES  (2)
  ) dut (
    .sclk               (sclk),
    .rstn               (rstn),
    .iclk               (iclk),
    .serial_in          (serial_in),
    .msg_flag           (msg_flag),
    .sclk_stop_rstn     (sclk_stop_rstn),
    .write_data         (write_data),
    .mux_control_signal (mux_control_signal)
  );

  initial iclk = 1'b0;
  always #5 iclk = ~iclk;

  always @(negedge iclk) begin
    if (rstn && !sclk_stop_rstn) stop_low_cnt <= stop_low_cnt + 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_bits   = 0;
    m_nbytes = 0;
    m_cur    = 8'h00;
    m_addr   = 8'h00;
    m_wd     = 8'h00;
    m_flag   = 1'b0;
  endtask

  task automatic model_bit(input logic b);
    m_cur[m_bits % 8] = b;
    m_bits++;
    m_flag = 1'b0;
    if (m_bits % 8 == 0) begin
      if (m_nbytes == 0) begin
        m_addr = m_cur;
      end else begin
        m_wd   = m_cur;
        m_addr = m_addr + 8'd1;
      end
      m_nbytes++;
      m_flag = 1'b1;
      m_cur  = 8'h00;
    end
  endtask

  task automatic send_bit(input logic b);
    serial_in = b;
    #40 sclk = 1'b1;
    model_bit(b);
    #10;
    chk("msg_flag", msg_flag, m_flag);
    chk("mux_ctl", mux_control_signal, m_addr);
    chk("wdata", write_data, m_wd);
    #30 sclk = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
  endtask

  task automatic align();
    @(negedge iclk);
    #2;
  endtask

  task automatic send_frame();
    align();
    foreach (frm[i]) send_byte(frm[i]);
  endtask

  task automatic wait_idle();
    int k;
    int lo;
    int start;
    int base;
    bit seen;
    k = 0;
    lo = 0;
    start = 0;
    seen = 1'b0;
    while (k < 200) begin
      @(negedge iclk);
      k++;
      if (!sclk_stop_rstn) begin
        if (!seen) begin
          seen  = 1'b1;
          start = k;
          chk("idle_mux", mux_control_signal, 8'h00);
          chk("idle_wdata", write_data, 8'h00);
          chk("idle_flag", msg_flag, 1'b0);
        end
        lo++;
      end else if (seen) begin
        break;
      end
    end
    chk("stop_seen", seen, 1'b1);
    chk("stop_delay", (start >= 64 && start <= 70), 1'b1);
    chk("stop_width", lo, 4);
    base = stop_low_cnt;
    repeat (150) @(negedge iclk);
    chk("stop_norepeat", stop_low_cnt - base, 0);
    model_reset();
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    stop_low_cnt = 0;
    sclk = 1'b0;
    serial_in = 1'b0;
    rstn = 1'b0;
    model_reset();
    #23;
    chk("rst_flag", msg_flag, 1'b0);
    chk("rst_wdata", write_data, 8'h00);
    chk("rst_mux", mux_control_signal, 8'h00);
    chk("rst_stop", sclk_stop_rstn, 1'b1);
    rstn = 1'b1;
    repeat (5) @(negedge iclk);

    frm = '{8'h02, 8'h03};
    send_frame();
    chk("f1_mux", mux_control_signal, 8'h03);
    chk("f1_wdata", write_data, 8'h03);
    wait_idle();

    frm = '{8'h3D, 8'hA5, 8'h5A, 8'hFF};
    send_frame();
    chk("burst_mux", mux_control_signal, 8'h40);
    chk("burst_wdata", write_data, 8'hFF);
    wait_idle();

    frm = '{8'hFF, 8'h11};
    send_frame();
    chk("wrap_mux", mux_control_signal, 8'h00);
    chk("wrap_wdata", write_data, 8'h11);
    wait_idle();

    align();
    for (int i = 0; i < 5; i++) send_bit(1'($urandom));
    wait_idle();

    frm = '{8'h01, 8'h0F};
    send_frame();
    chk("post_idle_mux", mux_control_signal, 8'h02);
    chk("post_idle_wdata", write_data, 8'h0F);
    wait_idle();

    align();
    send_byte(8'h5C);
    for (int i = 0; i < 4; i++) send_bit(1'($urandom));
    #10 rstn = 1'b0;
    #1;
    chk("arst_mux", mux_control_signal, 8'h00);
    chk("arst_wdata", write_data, 8'h00);
    chk("arst_flag", msg_flag, 1'b0);
    chk("arst_stop", sclk_stop_rstn, 1'b1);
    #20 rstn = 1'b1;
    model_reset();
    frm = '{8'h77, 8'hC3};
    send_frame();
    chk("arst_new_mux", mux_control_signal, 8'h78);
    wait_idle();

    begin
      int base;
      base = stop_low_cnt;
      frm.delete();
      for (int i = 0; i < 9; i++) frm.push_back(8'($urandom));
      send_frame();
      chk("cont_nostop", stop_low_cnt - base, 0);
      wait_idle();
    end

    for (int r = 0; r < 4; r++) begin
      int nd;
      nd = $urandom_range(1, 4);
      frm.delete();
      for (int i = 0; i <= nd; i++) frm.push_back(8'($urandom));
      send_frame();
      wait_idle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
